// File: rtl/mux_pipe_n.sv
// mux_pipe_n: registered N-way selector with a valid/ready output stage
// backed by a one-entry skid buffer. Define MUX_PIPE_SEL_CHECK_EN to zero
// out-of-range selects and raise the sticky sel_err flag.
module mux_pipe_n #(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 5,
  parameter int SEL_W  = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        signal,
  input  logic [INPUTS*WIDTH-1:0] data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_Out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] sel_val;
  logic             sel_oor;
  logic             accept;
  logic             consume;

  assign accept    = in_valid & in_ready_q;
  assign consume   = (state_q != EMPTY) & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign data_Out  = m_q;

`ifdef MUX_PIPE_SEL_CHECK_EN
  // Out-of-range only exists when INPUTS is not a power of two.
  if ((2 ** SEL_W) > INPUTS) begin : g_oor
    assign sel_oor = (32'(signal) >= 32'(INPUTS));
  end else begin : g_no_oor
    assign sel_oor = 1'b0;
  end
`else
  assign sel_oor = 1'b0;
`endif

  // Operand select; unmatched indices fall back to input 0.
  always_comb begin
    sel_val = data_in[WIDTH-1:0];
    for (int k = 1; k < INPUTS; k++) begin
      if (signal == SEL_W'(k)) begin
        sel_val = data_in[k*WIDTH +: WIDTH];
      end
    end
    if (sel_oor) begin
      sel_val = '0;
    end
  end

  // Next-state and storage steering for main/skid registers.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          m_d     = sel_val;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          m_d = sel_val;
        end else if (accept) begin
          s_d     = sel_val;
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, data and registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= (state_d != FULL);
    end
  end

`ifdef MUX_PIPE_SEL_CHECK_EN
  logic sel_err_q;

  // Sticky flag set when an out-of-range select is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: doc/mux_pipe_n.md
# mux_pipe_n

Parametrised, registered N-way selector with a valid/ready handshake, replacing the fixed 32-bit combinational selectors in the datapath where a select path must be retimed into its own cycle. It captures the selected operand into an output register backed by a one-entry skid buffer, so it sustains one transfer per cycle under downstream back-pressure without a combinational ready path. It sits between the operand sources (register file, ALU result, immediates) and any consumer that can stall.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output
- INPUTS, 5, number of selectable inputs (2..16)
- SEL_W, $clog2(INPUTS), width of the select port (derived; not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; sampled on rising clk edge
- signal  in  SEL_W  select index, sampled with in_valid
- data_in  in  INPUTS*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  1  upstream offers signal/data_in this cycle
- in_ready  out  1  block accepts this cycle; registered output
- data_Out  out  WIDTH  selected value, valid when out_valid=1
- out_valid  out  1  data_Out holds a transfer
- out_ready  in  1  downstream accepts data_Out this cycle
- sel_err  out  1  sticky out-of-range select flag (see Configuration)

## Operation
- Accept: in_valid & in_ready. Consume: out_valid & out_ready.
- Selection: value = data_in[signal*WIDTH +: WIDTH] for signal < INPUTS.
- Storage: main register M (drives data_Out) and skid register S.
- States:
  - EMPTY: out_valid=0, in_ready=1. Accept -> load M, go ONE.
  - ONE: out_valid=1, in_ready=1. Accept & consume -> load M, stay ONE. Accept & no consume -> load S, go FULL. Consume & no accept -> EMPTY. Neither -> hold.
  - FULL: out_valid=1, in_ready=0. Consume -> M<=S, go ONE. No consume -> hold. in_valid ignored.
- Order preserved; no transfer dropped or duplicated.
- data_Out stable while out_valid=1 and out_ready=0.
- data_in/signal changing while not accepted has no effect.

## Timing
- Latency: accepted in cycle t -> visible on data_Out/out_valid at cycle t+1 (EMPTY or ONE with consume).
- Throughput: 1 transfer/cycle with out_ready held 1.
- in_ready depends only on state (no combinational path from out_ready); drops to 0 the cycle after entering FULL.
- Reset: state EMPTY; out_valid=0, in_ready=1 during and after reset, data_Out=0, S=0, sel_err=0. Reset mid-transfer discards M and S contents; handshakes during a reset cycle are ignored.
- First accept allowed in the first cycle with reset=0.

## Configuration
- MUX_PIPE_SEL_CHECK_EN defined: accepted signal >= INPUTS selects all-zero data and sets sel_err at the same edge the entry is stored; sel_err stays 1 until reset. The entry still transfers normally.
- Not defined: out-of-range signal selects input 0 (data_in[WIDTH-1:0]); sel_err tied 0. Logic for the check is absent.
- When INPUTS is a power of two, out-of-range is impossible and sel_err stays 0 in both builds.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, data_Out=0, sel_err=0; no accept recorded.
- Streaming: INPUTS=5, inputs k = 32'h1000_0000+k, out_ready=1, signal 0,1,2,3,4 on consecutive cycles -> data_Out 1000_0000..1000_0004 on cycles t+1..t+5, out_valid continuous.
- Back-pressure: out_ready=0 while sending signal=2 then 3 -> state FULL, in_ready=0 from next cycle, data_Out=1000_0002 held; raise out_ready -> 1000_0002 then 1000_0003, in_ready back to 1 one cycle after first consume.
- Random stall: 1000 transfers, random in_valid/out_ready -> scoreboard matches order and values exactly, no loss/duplication.
- Out-of-range: signal=6, data_in nonzero -> with MUX_PIPE_SEL_CHECK_EN data_Out=0, sel_err=1 held until reset; without it data_Out=1000_0000, sel_err=0.
- Reset in FULL: fill M and S, assert reset 1 cycle -> out_valid=0, in_ready=1; subsequent first accept appears at t+1 with no stale data.
